// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: an enqueue side carrying the operation
// and a dequeue side carrying the result. Both sides use valid/ready.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    // Operation offered by the producer.
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits_lhs;
    logic [WIDTH-1:0] enq_bits_rhs;
    logic             enq_bits_cin;
    logic             enq_bits_sub;

    // Result taken by the consumer.
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits_sum;
    logic             deq_bits_cout;
    logic             deq_bits_ovf;

    // Producer/consumer side (e.g. the surrounding logic or a bench).
    modport master (
        output enq_valid, enq_bits_lhs, enq_bits_rhs, enq_bits_cin, enq_bits_sub, deq_ready,
        input  enq_ready, deq_valid, deq_bits_sum, deq_bits_cout, deq_bits_ovf
    );

    // Adder side.
    modport slave (
        input  enq_valid, enq_bits_lhs, enq_bits_rhs, enq_bits_cin, enq_bits_sub, deq_ready,
        output enq_ready, deq_valid, deq_bits_sum, deq_bits_cout, deq_bits_ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The operands are split into STAGES chunks of
// WIDTH/STAGES bits; stage k adds chunk k with the carry registered by stage
// k-1, so no carry chain is longer than one chunk. The whole pipeline advances
// in lock-step and freezes only while a finished result waits for the consumer.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              reset,
    pipelined_adder_if.slave io
);
    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic             enq_fire;
    logic             eff_cin;
    logic [WIDTH-1:0] eff_rhs;

    // The pipeline moves as a whole unless the output holds an untaken result;
    // bubbles therefore keep their slots during a stall.
    assign advance      = !io.deq_valid || io.deq_ready;
    assign io.enq_ready = !reset && advance;
    assign enq_fire     = io.enq_valid && io.enq_ready;

    // Subtraction is lhs + ~rhs + !cin, so invert once at the entrance.
    assign eff_rhs = io.enq_bits_sub ? ~io.enq_bits_rhs : io.enq_bits_rhs;
    assign eff_cin = io.enq_bits_sub ? !io.enq_bits_cin : io.enq_bits_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int UP = WIDTH - k * CHUNK;  // operand bits still to be added on entry
        localparam int LO = (k + 1) * CHUNK;    // result bits complete on exit

        logic [UP-1:0]  a_in;
        logic [UP-1:0]  b_in;
        logic           c_in;
        logic           v_in;
        logic [CHUNK:0] chunk_sum;
        logic [LO-1:0]  s_next;
        logic           v_q;
        logic           c_q;
        logic [LO-1:0]  s_q;

        // Only the lowest remaining chunk is added here.
        assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, c_in};

        if (k == 0) begin : g_src
            assign a_in   = io.enq_bits_lhs;
            assign b_in   = eff_rhs;
            assign c_in   = eff_cin;
            assign v_in   = enq_fire;
            assign s_next = chunk_sum[CHUNK-1:0];
        end else begin : g_src
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign s_next = {chunk_sum[CHUNK-1:0], g_stage[k-1].s_q};
        end

        // Stage register: valid flag, chunk carry and the low result bits so far.
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value.
        // NOTE: data registers are reset along with the valid bits so the result
        // bus reads zero during reset, not just "invalid".
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                c_q <= chunk_sum[CHUNK];
                s_q <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [UP-CHUNK-1:0] a_q;
            logic [UP-CHUNK-1:0] b_q;

            // Carry forward the operand chunks later stages still have to add.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[UP-1:CHUNK];
                    b_q <= b_in[UP-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // The operand MSBs and sum MSB meet only in the top chunk, so
            // signed overflow is resolved here.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (a_in[UP-1] == b_in[UP-1]) && (chunk_sum[CHUNK-1] != a_in[UP-1]);
                end
            end
        end
    end

    assign io.deq_valid     = g_stage[STAGES-1].v_q;
    assign io.deq_bits_sum  = g_stage[STAGES-1].s_q;
    assign io.deq_bits_cout = g_stage[STAGES-1].c_q;
    assign io.deq_bits_ovf  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder. Three instances share one clock:
//   0: WIDTH=8,  STAGES=2 (directed cases)
//   1: WIDTH=32, STAGES=4 (random traffic)
//   2: WIDTH=8,  STAGES=1 (random traffic)
// Inputs change on the falling edge; outputs are read 1 time unit later.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  drv_valid;
    logic [2:0]  drv_ready;
    logic [2:0]  drv_cin;
    logic [2:0]  drv_sub;
    logic [31:0] drv_lhs [3];
    logic [31:0] drv_rhs [3];
    logic [2:0]  obs_enq_ready;
    logic [2:0]  obs_deq_valid;
    logic [63:0] obs_res [3];   // {ovf at bit 33, cout at bit 32, sum zero-extended}

    int checks = 0;
    int errors = 0;

    pipelined_adder_if #(.WIDTH(8))  if_a ();
    pipelined_adder_if #(.WIDTH(32)) if_b ();
    pipelined_adder_if #(.WIDTH(8))  if_c ();

    assign if_a.enq_valid    = drv_valid[0];
    assign if_a.deq_ready    = drv_ready[0];
    assign if_a.enq_bits_lhs = drv_lhs[0][7:0];
    assign if_a.enq_bits_rhs = drv_rhs[0][7:0];
    assign if_a.enq_bits_cin = drv_cin[0];
    assign if_a.enq_bits_sub = drv_sub[0];
    assign obs_enq_ready[0]  = if_a.enq_ready;
    assign obs_deq_valid[0]  = if_a.deq_valid;
    assign obs_res[0] = {30'b0, if_a.deq_bits_ovf, if_a.deq_bits_cout, 24'b0, if_a.deq_bits_sum};

    assign if_b.enq_valid    = drv_valid[1];
    assign if_b.deq_ready    = drv_ready[1];
    assign if_b.enq_bits_lhs = drv_lhs[1];
    assign if_b.enq_bits_rhs = drv_rhs[1];
    assign if_b.enq_bits_cin = drv_cin[1];
    assign if_b.enq_bits_sub = drv_sub[1];
    assign obs_enq_ready[1]  = if_b.enq_ready;
    assign obs_deq_valid[1]  = if_b.deq_valid;
    assign obs_res[1] = {30'b0, if_b.deq_bits_ovf, if_b.deq_bits_cout, if_b.deq_bits_sum};

    assign if_c.enq_valid    = drv_valid[2];
    assign if_c.deq_ready    = drv_ready[2];
    assign if_c.enq_bits_lhs = drv_lhs[2][7:0];
    assign if_c.enq_bits_rhs = drv_rhs[2][7:0];
    assign if_c.enq_bits_cin = drv_cin[2];
    assign if_c.enq_bits_sub = drv_sub[2];
    assign obs_enq_ready[2]  = if_c.enq_ready;
    assign obs_deq_valid[2]  = if_c.deq_valid;
    assign obs_res[2] = {30'b0, if_c.deq_bits_ovf, if_c.deq_bits_cout, 24'b0, if_c.deq_bits_sum};

    pipelined_adder #(.WIDTH(8),  .STAGES(2)) dut_a (.clk(clk), .reset(rst[0]), .io(if_a));
    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut_b (.clk(clk), .reset(rst[1]), .io(if_b));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut_c (.clk(clk), .reset(rst[2]), .io(if_c));

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] pack_res(input logic [31:0] sum, input logic cout, input logic ovf);
        logic [63:0] r;
        r = '0;
        r[31:0] = sum;
        r[32]   = cout;
        r[33]   = ovf;
        return r;
    endfunction

    // Integer-arithmetic reference: unsigned result gives sum/cout, the true
    // signed result gives overflow.
    function automatic logic [63:0] ref_result(input int w, input logic [31:0] lhs,
                                               input logic [31:0] rhs, input logic cin,
                                               input logic sub);
        longint m, a, b, sa, sb, ci, u, s;
        logic   cout, ovf;
        m  = longint'(1) << w;
        a  = longint'(lhs) & (m - 1);
        b  = longint'(rhs) & (m - 1);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        ci = cin ? 1 : 0;
        if (sub) begin
            u    = a - b - ci;
            s    = sa - sb - ci;
            cout = (u >= 0);
        end else begin
            u    = a + b + ci;
            s    = sa + sb + ci;
            cout = (u >= m);
        end
        ovf = (s < -(m / 2)) || (s >= m / 2);
        return pack_res(32'(u & (m - 1)), cout, ovf);
    endfunction

    task automatic drive_op(input int id, input logic [31:0] lhs, input logic [31:0] rhs,
                            input logic cin, input logic sub);
        drv_valid[id] = 1'b1;
        drv_lhs[id]   = lhs;
        drv_rhs[id]   = rhs;
        drv_cin[id]   = cin;
        drv_sub[id]   = sub;
    endtask

    // 0xFF + 0x01 with exact two-cycle latency.
    task automatic directed_latency();
        @(negedge clk);
        drv_ready[0] = 1'b1;
        drive_op(0, 32'hFF, 32'h01, 1'b0, 1'b0);
        #1;
        check("lat_enq_ready", obs_enq_ready[0], 1);
        @(negedge clk);
        drv_valid[0] = 1'b0;
        #1;
        check("lat_cycle1_valid", obs_deq_valid[0], 0);
        @(negedge clk);
        #1;
        check("lat_cycle2_valid", obs_deq_valid[0], 1);
        check("add_ff_01", obs_res[0], pack_res(32'h00, 1'b1, 1'b0));
        @(negedge clk);
        #1;
        check("lat_drained", obs_deq_valid[0], 0);
    endtask

    // Four back-to-back operations, one result per cycle.
    task automatic directed_stream();
        logic [31:0] lhs_t [4] = '{32'h7F, 32'h0F, 32'h05, 32'h80};
        logic [31:0] rhs_t [4] = '{32'h01, 32'h01, 32'h07, 32'h01};
        logic        sub_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] exp_t [4];
        exp_t[0] = pack_res(32'h80, 1'b0, 1'b1);
        exp_t[1] = pack_res(32'h10, 1'b0, 1'b0);
        exp_t[2] = pack_res(32'hFE, 1'b0, 1'b0);
        exp_t[3] = pack_res(32'h7F, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) drive_op(0, lhs_t[c], rhs_t[c], 1'b0, sub_t[c]);
            else       drv_valid[0] = 1'b0;
            #1;
            if (c < 4) check($sformatf("stream_enq_ready_%0d", c), obs_enq_ready[0], 1);
            if (c >= 2) begin
                check($sformatf("stream_valid_%0d", c), obs_deq_valid[0], 1);
                check($sformatf("stream_result_%0d", c - 2), obs_res[0], exp_t[c-2]);
            end else begin
                check($sformatf("stream_valid_%0d", c), obs_deq_valid[0], 0);
            end
        end
        @(negedge clk);
        #1;
        check("stream_drained", obs_deq_valid[0], 0);
    endtask

    // Four operations with the consumer stalled for three cycles.
    task automatic directed_backpressure();
        logic [31:0] lhs_t [4] = '{32'h12, 32'hF0, 32'hAA, 32'h01};
        logic [31:0] rhs_t [4] = '{32'h34, 32'h0F, 32'h55, 32'h02};
        logic        cin_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        sub_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int          sent = 0;
        int          got = 0;
        int          stalls = 0;
        bit          held_v = 1'b0;
        logic [63:0] held = '0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (sent < 4) drive_op(0, lhs_t[sent], rhs_t[sent], cin_t[sent], sub_t[sent]);
            else          drv_valid[0] = 1'b0;
            drv_ready[0] = !(c >= 2 && c <= 4);
            #1;
            if (held_v) check("bp_hold", obs_res[0], held);
            if (obs_deq_valid[0] && !drv_ready[0]) begin
                stalls++;
                check("bp_enq_ready_low", obs_enq_ready[0], 0);
            end
            held_v = obs_deq_valid[0] && !drv_ready[0];
            held   = obs_res[0];
            if (obs_deq_valid[0] && drv_ready[0]) begin
                check($sformatf("bp_result_%0d", got), obs_res[0],
                      ref_result(8, lhs_t[got], rhs_t[got], cin_t[got], sub_t[got]));
                got++;
            end
            if (drv_valid[0] && obs_enq_ready[0]) sent++;
        end
        check("bp_count", got, 4);
        check("bp_stall_cycles", stalls, 3);
        @(negedge clk);
        drv_valid[0] = 1'b0;
        drv_ready[0] = 1'b1;
        #1;
        check("bp_no_dup", obs_deq_valid[0], 0);
    endtask

    // Reset asserted between edges with two operations in flight.
    task automatic directed_reset_midflight();
        int stale = 0;
        @(negedge clk);
        drv_ready[0] = 1'b1;
        drive_op(0, 32'h33, 32'h44, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(0, 32'h99, 32'h11, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drv_valid[0] = 1'b0;
        #2;
        check("rmf_pre_valid", obs_deq_valid[0], 1);
        rst[0] = 1'b1;
        #1;
        check("rmf_valid_low", obs_deq_valid[0], 0);
        check("rmf_result_zero", obs_res[0], 0);
        check("rmf_enq_ready_low", obs_enq_ready[0], 0);
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        check("rmf_enq_ready_after", obs_enq_ready[0], 1);
        repeat (6) begin
            @(negedge clk);
            #1;
            if (obs_deq_valid[0]) stale++;
        end
        check("rmf_stale", stale, 0);
    endtask

    // Random operations with random valid/ready, scored against ref_result.
    task automatic run_random(input int id, input int w, input int n);
        logic [63:0] exp_q [$];
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        bit          held_v = 1'b0;
        logic [63:0] held = '0;
        while (got < n && cyc < 40000) begin
            @(negedge clk);
            drv_valid[id] = (sent < n) && ($urandom_range(0, 4) != 0);
            drv_ready[id] = ($urandom_range(0, 4) != 0);
            drv_lhs[id]   = $urandom;
            drv_rhs[id]   = $urandom;
            if ($urandom_range(0, 7) == 0) drv_lhs[id] = '1;
            if ($urandom_range(0, 7) == 0) drv_rhs[id] = 32'h8000_0080;
            drv_cin[id]   = 1'($urandom_range(0, 1));
            drv_sub[id]   = 1'($urandom_range(0, 1));
            #1;
            if (held_v) begin
                check($sformatf("rnd%0d_hold_valid", id), obs_deq_valid[id], 1);
                check($sformatf("rnd%0d_hold_data", id), obs_res[id], held);
            end
            held_v = obs_deq_valid[id] && !drv_ready[id];
            held   = obs_res[id];
            if (obs_deq_valid[id] && drv_ready[id]) begin
                check($sformatf("rnd%0d_expected_pending", id), exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check($sformatf("rnd%0d_result_%0d", id, got), obs_res[id], exp_q.pop_front());
                got++;
            end
            if (drv_valid[id] && obs_enq_ready[id]) begin
                exp_q.push_back(ref_result(w, drv_lhs[id], drv_rhs[id], drv_cin[id], drv_sub[id]));
                sent++;
            end
            cyc++;
        end
        check($sformatf("rnd%0d_sent", id), sent, n);
        check($sformatf("rnd%0d_got", id), got, n);
        @(negedge clk);
        drv_valid[id] = 1'b0;
        drv_ready[id] = 1'b1;
    endtask

    initial begin
        rst       = '0;
        drv_valid = '0;
        drv_ready = '1;
        drv_cin   = '0;
        drv_sub   = '0;
        for (int i = 0; i < 3; i++) begin
            drv_lhs[i] = '0;
            drv_rhs[i] = '0;
        end
        #1;
        rst = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_enq_ready_%0d", i), obs_enq_ready[i], 0);
            check($sformatf("reset_deq_valid_%0d", i), obs_deq_valid[i], 0);
            check($sformatf("reset_result_%0d", i), obs_res[i], 0);
        end
        rst = '0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("release_enq_ready_%0d", i), obs_enq_ready[i], 1);

        directed_latency();
        directed_stream();
        directed_backpressure();
        directed_reset_midflight();
        run_random(1, 32, 10000);
        run_random(2, 8, 10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
